// File: rtl/led_scroll_ctrl.sv
// Scrolling 10-LED pattern controller: rotate or bounce the pattern every DIV clocks,
// with a one-cycle LOAD state for replacing the pattern.
module led_scroll_ctrl #(
  parameter int unsigned DIV = 50000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic       dir,
  input  logic       bounce,
  input  logic       load_valid,
  input  logic [9:0] load_data,
  output logic       load_ready,
  output logic [9:0] led,
  output logic       step,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StLoad = 2'd2
  } state_e;

  localparam logic [25:0] CntMax = 26'(DIV - 1);

  state_e      state_q;
  logic [25:0] cnt_q;
  logic        bdir_q;
  logic        accept;
  logic [9:0]  next_led;
  logic        next_bdir;

  assign accept = load_valid & load_ready;
  assign state  = state_q;

  // Pattern for the next step; bdir only matters in bounce mode.
  always_comb begin
    next_led  = led;
    next_bdir = bdir_q;
    if (!bounce) begin
      next_led = dir ? {led[0], led[9:1]} : {led[8:0], led[9]};
    end else begin
      if ((!bdir_q && led[9]) || (bdir_q && led[0])) begin
        next_bdir = ~bdir_q;
      end
      // A full bar cannot move in either direction, so it stays put.
      if (led != 10'h3FF) begin
        next_led = next_bdir ? {1'b0, led[9:1]} : {led[8:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      led        <= 10'd1;
      cnt_q      <= '0;
      state_q    <= StIdle;
      bdir_q     <= 1'b0;
      step       <= 1'b0;
      load_ready <= 1'b1;
    end else begin
      step       <= 1'b0;
      load_ready <= 1'b1;
      if (!bounce) begin
        bdir_q <= dir;
      end
      if (accept) begin
        led        <= (load_data == 10'd0) ? 10'd1 : load_data;
        cnt_q      <= '0;
        state_q    <= StLoad;
        load_ready <= 1'b0;
      end else begin
        case (state_q)
          StRun: begin
            if (cnt_q == CntMax) begin
              cnt_q <= '0;
              led   <= next_led;
              step  <= 1'b1;
              if (bounce) begin
                bdir_q <= next_bdir;
              end
            end else begin
              cnt_q <= cnt_q + 26'd1;
            end
            state_q <= run ? StRun : StIdle;
          end
          StIdle, StLoad: state_q <= run ? StRun : StIdle;
          default:        state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_led_scroll_ctrl.sv
// Scoreboard bench for led_scroll_ctrl: a behavioural model queues expected outputs per cycle,
// and a monitor compares them against the DUT on the falling edge.
module tb_led_scroll_ctrl;

  localparam int Div = 4;

  logic       clk = 1'b0;
  logic       rst, run, dir, bounce, load_valid;
  logic [9:0] load_data;
  logic       load_ready, step;
  logic [9:0] led;
  logic [1:0] state;

  led_scroll_ctrl #(.DIV(Div)) dut (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .dir        (dir),
    .bounce     (bounce),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .led        (led),
    .step       (step),
    .state      (state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [9:0] led;
    logic       step;
    logic [1:0] state;
    logic       rdy;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Model state: phase counts RUN cycles since the last step/load/reset.
  int   m_led   = 1;
  int   m_phase = 0;
  int   m_state = 0;
  bit   m_bdir  = 0;
  bit   m_step  = 0;
  bit   m_rdy   = 1;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("led", int'(led), int'(e.led));
      check("step", int'(step), int'(e.step));
      check("state", int'(state), int'(e.state));
      check("load_ready", int'(load_ready), int'(e.rdy));
    end
  end

  // Drive one cycle of inputs, advance the reference model, queue its outputs.
  task automatic tick(input bit r, input bit ru, input bit d, input bit b, input bit lv,
                      input int ld);
    int  nled, nphase, nstate;
    bit  nbdir, nstep, go;
    rst = r; run = ru; dir = d; bounce = b; load_valid = lv; load_data = 10'(ld);
    if (r) begin
      nled = 1; nphase = 0; nstate = 0; nbdir = 0; nstep = 0;
    end else begin
      nled = m_led; nphase = m_phase; nstep = 0;
      nbdir = b ? m_bdir : d;
      if (lv && m_rdy) begin
        nled = (ld == 0) ? 1 : ld;
        nphase = 0;
        nstate = 2;
      end else begin
        nstate = ru ? 1 : 0;
        if (m_state == 1) begin
          nphase = m_phase + 1;
          if (nphase == Div) begin
            nphase = 0;
            nstep = 1;
            if (!b) begin
              if (d) nled = (m_led >> 1) | ((m_led & 1) << 9);
              else   nled = ((m_led << 1) & 'h3FF) | (m_led >> 9);
            end else begin
              go = m_bdir;
              if ((!go && m_led >= 'h200) || (go && (m_led % 2 == 1))) go = !go;
              nbdir = go;
              if (m_led != 'h3FF) nled = go ? (m_led >> 1) : ((m_led * 2) % 1024);
            end
          end
        end
      end
    end
    m_led = nled; m_phase = nphase; m_state = nstate; m_bdir = nbdir;
    m_step = nstep; m_rdy = (nstate != 2);
    @(posedge clk);
    exp_q.push_back('{led: 10'(m_led), step: m_step, state: 2'(m_state), rdy: m_rdy});
    #1;
  endtask

  task automatic run_n(input int n, input bit d, input bit b);
    for (int i = 0; i < n; i++) tick(0, 1, d, b, 0, 0);
  endtask

  initial begin
    rst = 1; run = 0; dir = 0; bounce = 0; load_valid = 0; load_data = '0;
    @(posedge clk); #1;
    tick(1, 0, 0, 0, 0, 0);
    tick(1, 1, 1, 1, 1, 'h155);

    // Rotate left through more than a full revolution, then rotate right.
    run_n(45, 0, 0);
    tick(1, 0, 0, 0, 0, 0);
    run_n(12, 1, 0);

    // Bounce from the top end, then from the bottom end heading right.
    tick(0, 1, 0, 0, 1, 'h200);
    run_n(30, 0, 1);
    tick(0, 1, 1, 0, 1, 'h001);
    run_n(12, 1, 1);
    tick(0, 1, 0, 0, 1, 'h3FF);
    run_n(10, 0, 1);

    // Pause at phase 2 for 7 cycles, then resume.
    tick(1, 0, 0, 0, 0, 0);
    run_n(3, 0, 0);
    for (int i = 0; i < 7; i++) tick(0, 0, 0, 0, 0, 0);
    run_n(8, 0, 0);

    // Load on a step-due cycle, then a zero load.
    tick(1, 0, 0, 0, 0, 0);
    run_n(4, 0, 0);
    tick(0, 1, 0, 0, 1, 'h155);
    tick(0, 1, 0, 0, 1, 'h0AA);
    run_n(3, 0, 0);
    tick(0, 1, 0, 0, 1, 'h000);
    run_n(6, 0, 0);

    // Reset mid-RUN with a load pending.
    tick(1, 0, 0, 0, 0, 0);
    run_n(4, 0, 0);
    tick(1, 1, 0, 0, 1, 'h155);
    run_n(6, 0, 0);

    for (int i = 0; i < 1500; i++) begin
      tick(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) != 0),
           ($urandom_range(0, 15) == 0) ? !dir : dir,
           ($urandom_range(0, 31) == 0) ? !bounce : bounce,
           ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 1023)));
    end

    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected outputs never compared, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
